// File: rtl/min_sopc_if.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module      : min_sopc_if
// Description : Instruction-fetch bus between the core and the instruction
//               ROM. The core drives the fetch address and enable, and the
//               ROM returns the addressed word combinationally.
//   pc   : byte address of the instruction to fetch
//   ce   : fetch enable; the ROM returns 0 while this is low
//   inst : instruction word returned by the ROM
// Revision    : 1.0 - initial release
// ============================================================================
interface min_sopc_if;
  logic [31:0] pc;
  logic        ce;
  logic [31:0] inst;

  modport master (output pc, output ce, input inst);
  modport slave  (input pc, input ce, output inst);
endinterface
`default_nettype wire

// File: rtl/min_sopc.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module      : min_sopc (plus min_sopc_rom, min_sopc_regfile, min_sopc_cpu)
// Description : Minimal SoC. A 5-stage in-order MIPS32-subset core fetches
//               from a preloaded instruction ROM. There is no data memory and
//               no external I/O.
//   clk : system clock, rising-edge active
//   rst : asynchronous, active-low reset
// Revision    : 1.0 - initial release
// ============================================================================

// Instruction ROM: combinational read, word index taken from the byte pc.
module min_sopc_rom #(
  parameter int ROM_DEPTH = 1024,
  parameter int ROM_AW    = 10
) (
  min_sopc_if.slave rom_bus
);
  logic [31:0] inst_mem [0:ROM_DEPTH-1];

  // Upper pc bits are dropped on purpose: fetch wraps around the ROM.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{rom_bus.pc[31:ROM_AW+2], rom_bus.pc[1:0]};

  assign rom_bus.inst = rom_bus.ce ? inst_mem[rom_bus.pc[ROM_AW+1:2]] : 32'h0;
endmodule

// General-purpose registers 1..31; $0 reads as zero. Write-through, so a
// same-cycle write-back is visible to the decode-stage read.
module min_sopc_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2
);
  logic [31:0] storage [1:31];

  always_ff @(posedge clk) begin
    if (we && waddr != 5'd0) storage[waddr] <= wdata;
  end

  always_comb begin
    rdata1 = 32'h0;
    rdata2 = 32'h0;
    if (raddr1 != 5'd0) rdata1 = (we && waddr == raddr1) ? wdata : storage[raddr1];
    if (raddr2 != 5'd0) rdata2 = (we && waddr == raddr2) ? wdata : storage[raddr2];
  end
endmodule

// Core: IF -> ID -> EX -> MEM -> WB, GPR and HI/LO written at the WB edge.
module min_sopc_cpu (
  input  logic       clk,
  input  logic       rst,
  min_sopc_if.master rom_bus
);
  localparam logic [3:0] OP_NOP  = 4'd0,  OP_OR   = 4'd1,  OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3,  OP_NOR  = 4'd4,  OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6,  OP_SRA  = 4'd7,  OP_MOV  = 4'd8;
  localparam logic [3:0] OP_MFHI = 4'd9,  OP_MFLO = 4'd10, OP_MTHI = 4'd11;
  localparam logic [3:0] OP_MTLO = 4'd12;

  // ---------------- IF ----------------
  logic [31:0] pc;
  logic        ce;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce <= 1'b0;
      pc <= 32'h0;
    end else begin
      ce <= 1'b1;
      if (ce) pc <= pc + 32'd4;
    end
  end
  assign rom_bus.pc = pc;
  assign rom_bus.ce = ce;

  logic [31:0] if_id_inst;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) if_id_inst <= 32'h0;
    else      if_id_inst <= rom_bus.inst;
  end

  // ---------------- ID ----------------
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  assign opcode = if_id_inst[31:26];
  assign rs     = if_id_inst[25:21];
  assign rt     = if_id_inst[20:16];
  assign rd     = if_id_inst[15:11];
  assign shamt  = if_id_inst[10:6];
  assign funct  = if_id_inst[5:0];
  assign imm    = if_id_inst[15:0];

  logic [31:0] rf_rdata1, rf_rdata2, rs_val, rt_val;
  logic [3:0]  id_op;
  logic [31:0] id_src1, id_src2;
  logic [4:0]  id_wd;
  logic        id_wen;

  // Stage signals declared ahead for forwarding.
  logic [3:0]  ex_op;
  logic [31:0] ex_src1, ex_src2, ex_wdata;
  logic [4:0]  ex_shamt, ex_wd;
  logic        ex_wreg;
  logic [4:0]  mem_wd, wb_wd;
  logic [31:0] mem_wdata, wb_wdata;
  logic        mem_wreg, mem_whi, mem_wlo, wb_wreg, wb_whi, wb_wlo;
  logic [31:0] hi, lo;

  min_sopc_regfile register (
    .clk    (clk),
    .we     (wb_wreg),
    .waddr  (wb_wd),
    .wdata  (wb_wdata),
    .raddr1 (rs),
    .rdata1 (rf_rdata1),
    .raddr2 (rt),
    .rdata2 (rf_rdata2)
  );

  // Writes to $0 are squashed at decode, so a match on register 0 never
  // happens and $0 always comes from the regfile as zero.
  always_comb begin
    if (ex_wreg && ex_wd == rs)        rs_val = ex_wdata;
    else if (mem_wreg && mem_wd == rs) rs_val = mem_wdata;
    else                               rs_val = rf_rdata1;
    if (ex_wreg && ex_wd == rt)        rt_val = ex_wdata;
    else if (mem_wreg && mem_wd == rt) rt_val = mem_wdata;
    else                               rt_val = rf_rdata2;
  end

  always_comb begin
    id_op   = OP_NOP;
    id_src1 = rs_val;
    id_src2 = rt_val;
    id_wd   = rd;
    id_wen  = 1'b0;
    case (opcode)
      6'h0D: begin id_op = OP_OR;  id_src2 = {16'h0, imm}; id_wd = rt; id_wen = 1'b1; end
      6'h0C: begin id_op = OP_AND; id_src2 = {16'h0, imm}; id_wd = rt; id_wen = 1'b1; end
      6'h0E: begin id_op = OP_XOR; id_src2 = {16'h0, imm}; id_wd = rt; id_wen = 1'b1; end
      6'h0F: begin
        id_op = OP_OR; id_src1 = {imm, 16'h0}; id_src2 = 32'h0; id_wd = rt; id_wen = 1'b1;
      end
      6'h00: begin
        case (funct)
          6'h24: begin id_op = OP_AND; id_wen = 1'b1; end
          6'h25: begin id_op = OP_OR;  id_wen = 1'b1; end
          6'h26: begin id_op = OP_XOR; id_wen = 1'b1; end
          6'h27: begin id_op = OP_NOR; id_wen = 1'b1; end
          6'h00: begin id_op = OP_SLL; id_src1 = rt_val; id_wen = 1'b1; end
          6'h02: begin id_op = OP_SRL; id_src1 = rt_val; id_wen = 1'b1; end
          6'h03: begin id_op = OP_SRA; id_src1 = rt_val; id_wen = 1'b1; end
          // Conditional moves resolve here on the forwarded rt value, so a
          // false condition also removes the result from the forward paths.
          6'h0A: begin id_op = OP_MOV;  id_wen = (rt_val == 32'h0); end
          6'h0B: begin id_op = OP_MOV;  id_wen = (rt_val != 32'h0); end
          6'h10: begin id_op = OP_MFHI; id_wen = 1'b1; end
          6'h12: begin id_op = OP_MFLO; id_wen = 1'b1; end
          6'h11: id_op = OP_MTHI;
          6'h13: id_op = OP_MTLO;
          default: id_op = OP_NOP;
        endcase
      end
      default: id_op = OP_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_op    <= OP_NOP;
      ex_src1  <= 32'h0;
      ex_src2  <= 32'h0;
      ex_shamt <= 5'd0;
      ex_wd    <= 5'd0;
      ex_wreg  <= 1'b0;
    end else begin
      ex_op    <= id_op;
      ex_src1  <= id_src1;
      ex_src2  <= id_src2;
      ex_shamt <= shamt;
      ex_wd    <= id_wd;
      ex_wreg  <= id_wen && (id_wd != 5'd0);
    end
  end

  // ---------------- EX ----------------
  // The youngest pending HI/LO write wins: MEM stage first, then WB stage.
  logic [31:0] hi_fwd, lo_fwd;
  always_comb begin
    if (mem_whi)     hi_fwd = mem_wdata;
    else if (wb_whi) hi_fwd = wb_wdata;
    else             hi_fwd = hi;
    if (mem_wlo)     lo_fwd = mem_wdata;
    else if (wb_wlo) lo_fwd = wb_wdata;
    else             lo_fwd = lo;
  end

  always_comb begin
    ex_wdata = 32'h0;
    case (ex_op)
      OP_OR:   ex_wdata = ex_src1 | ex_src2;
      OP_AND:  ex_wdata = ex_src1 & ex_src2;
      OP_XOR:  ex_wdata = ex_src1 ^ ex_src2;
      OP_NOR:  ex_wdata = ~(ex_src1 | ex_src2);
      OP_SLL:  ex_wdata = ex_src1 << ex_shamt;
      OP_SRL:  ex_wdata = ex_src1 >> ex_shamt;
      OP_SRA:  ex_wdata = $unsigned($signed(ex_src1) >>> ex_shamt);
      OP_MOV, OP_MTHI, OP_MTLO: ex_wdata = ex_src1;
      OP_MFHI: ex_wdata = hi_fwd;
      OP_MFLO: ex_wdata = lo_fwd;
      default: ex_wdata = 32'h0;
    endcase
  end

  // ---------------- EX/MEM (MEM is a pass-through) ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wd <= 5'd0; mem_wdata <= 32'h0; mem_wreg <= 1'b0; mem_whi <= 1'b0; mem_wlo <= 1'b0;
    end else begin
      mem_wd    <= ex_wd;
      mem_wdata <= ex_wdata;
      mem_wreg  <= ex_wreg;
      mem_whi   <= (ex_op == OP_MTHI);
      mem_wlo   <= (ex_op == OP_MTLO);
    end
  end

  // ---------------- MEM/WB ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wd <= 5'd0; wb_wdata <= 32'h0; wb_wreg <= 1'b0; wb_whi <= 1'b0; wb_wlo <= 1'b0;
    end else begin
      wb_wd    <= mem_wd;
      wb_wdata <= mem_wdata;
      wb_wreg  <= mem_wreg;
      wb_whi   <= mem_whi;
      wb_wlo   <= mem_wlo;
    end
  end

  // ---------------- HI/LO ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= 32'h0;
      lo <= 32'h0;
    end else begin
      if (wb_whi) hi <= wb_wdata;
      if (wb_wlo) lo <= wb_wdata;
    end
  end
endmodule

module min_sopc #(
  parameter int ROM_DEPTH = 1024,
  parameter int ROM_AW    = 10
) (
  input logic clk,
  input logic rst
);
  min_sopc_if rom_bus ();

  min_sopc_cpu cpu (
    .clk     (clk),
    .rst     (rst),
    .rom_bus (rom_bus.master)
  );

  min_sopc_rom #(
    .ROM_DEPTH (ROM_DEPTH),
    .ROM_AW    (ROM_AW)
  ) inst_rom0 (
    .rom_bus (rom_bus.slave)
  );
endmodule
`default_nettype wire

// File: tb/tb_min_sopc.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module      : tb_min_sopc
// Description : Directed program bench for min_sopc. Expected register-file
//               and HI/LO commits are queued with their commit edge; a monitor
//               compares every write-back the core presents against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_min_sopc;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt;

  typedef struct {
    int          edge_n;
    int          kind;   // 0 GPR, 1 HI, 2 LO
    int          addr;
    logic [31:0] data;
  } commit_t;
  commit_t exp_q[$];

  min_sopc dut (.clk(clk), .rst(rst));

  // Mirror of the fetch bus for probing.
  min_sopc_if probe_bus ();
  assign probe_bus.pc   = dut.rom_bus.pc;
  assign probe_bus.ce   = dut.rom_bus.ce;
  assign probe_bus.inst = dut.rom_bus.inst;

  initial clk = 1'b0;
  always #1 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    logic [31:0] w;
    w = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
    logic [31:0] w;
    w = {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    return w;
  endfunction

  task automatic push(int e, int kind, int addr, logic [31:0] d);
    commit_t c;
    c.edge_n = e; c.kind = kind; c.addr = addr; c.data = d;
    exp_q.push_back(c);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic observe(int kind, int addr, logic [31:0] data);
    commit_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL commit: got kind=%0d addr=%0d data=%h at edge %0d, required no write",
               kind, addr, data, edge_cnt + 1);
    end else begin
      e = exp_q.pop_front();
      if (e.edge_n != edge_cnt + 1 || e.kind != kind || e.addr != addr || e.data !== data) begin
        errors++;
        $display("FAIL commit: got edge=%0d kind=%0d addr=%0d data=%h, required edge=%0d kind=%0d addr=%0d data=%h",
                 edge_cnt + 1, kind, addr, data, e.edge_n, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: write-back values seen at the falling edge commit on the next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (dut.cpu.wb_wreg) observe(0, int'(dut.cpu.wb_wd), dut.cpu.wb_wdata);
      if (dut.cpu.wb_whi)  observe(1, 0, dut.cpu.wb_wdata);
      if (dut.cpu.wb_wlo)  observe(2, 0, dut.cpu.wb_wdata);
    end
  end

  task automatic wait_edge(int n);
    int guard = 0;
    do begin
      @(posedge clk);
      #0.5;
      guard++;
    end while (edge_cnt < n && guard < 200);
    if (edge_cnt < n) begin
      checks++; errors++;
      $display("FAIL timeout: edge %0d, required %0d", edge_cnt, n);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) dut.inst_rom0.inst_mem[i] = 32'h0;
  endtask

  logic [31:0] prog2 [0:25];
  logic [31:0] gpr_exp [1:24];

  initial begin
    rst = 1'b0;
    clear_rom();
    // Program 1
    dut.inst_rom0.inst_mem[0]  = enc_i(6'h0F, 0, 1, 16'h0000);
    dut.inst_rom0.inst_mem[1]  = enc_i(6'h0F, 0, 2, 16'hFFFF);
    dut.inst_rom0.inst_mem[2]  = enc_i(6'h0F, 0, 3, 16'h0505);
    dut.inst_rom0.inst_mem[3]  = enc_i(6'h0F, 0, 4, 16'h0000);
    dut.inst_rom0.inst_mem[4]  = enc_r(2, 1, 4, 0, 6'h0A);
    dut.inst_rom0.inst_mem[5]  = enc_r(3, 1, 4, 0, 6'h0B);
    dut.inst_rom0.inst_mem[6]  = enc_r(3, 2, 4, 0, 6'h0B);
    dut.inst_rom0.inst_mem[7]  = enc_r(2, 3, 4, 0, 6'h0A);
    dut.inst_rom0.inst_mem[8]  = enc_r(0, 0, 0, 0, 6'h11);
    dut.inst_rom0.inst_mem[9]  = enc_r(2, 0, 0, 0, 6'h11);
    dut.inst_rom0.inst_mem[10] = enc_r(3, 0, 0, 0, 6'h11);
    dut.inst_rom0.inst_mem[11] = enc_r(0, 0, 4, 0, 6'h10);
    dut.inst_rom0.inst_mem[12] = enc_r(3, 0, 0, 0, 6'h13);
    dut.inst_rom0.inst_mem[13] = enc_r(2, 0, 0, 0, 6'h13);
    dut.inst_rom0.inst_mem[14] = enc_r(1, 0, 0, 0, 6'h13);
    dut.inst_rom0.inst_mem[15] = enc_r(0, 0, 4, 0, 6'h12);
    dut.inst_rom0.inst_mem[16] = 32'hFC0A_0001;
    dut.inst_rom0.inst_mem[17] = enc_i(6'h0D, 0, 20, 16'hBEEF);
    dut.inst_rom0.inst_mem[18] = enc_r(2, 0, 0, 0, 6'h11);

    push(6, 0, 1, 32'h0000_0000);  push(7, 0, 2, 32'hFFFF_0000);
    push(8, 0, 3, 32'h0505_0000);  push(9, 0, 4, 32'h0000_0000);
    push(10, 0, 4, 32'hFFFF_0000); push(12, 0, 4, 32'h0505_0000);
    push(14, 1, 0, 32'h0000_0000); push(15, 1, 0, 32'hFFFF_0000);
    push(16, 1, 0, 32'h0505_0000); push(17, 0, 4, 32'h0505_0000);
    push(18, 2, 0, 32'h0505_0000); push(19, 2, 0, 32'hFFFF_0000);
    push(20, 2, 0, 32'h0000_0000); push(21, 0, 4, 32'h0000_0000);

    #5;
    check("reset_pc", dut.cpu.pc, 32'h0);
    check("reset_ce", {31'h0, dut.cpu.ce}, 32'h0);
    check("reset_rom_inst", probe_bus.inst, 32'h0);
    check("reset_ifid", dut.cpu.if_id_inst, 32'h0);
    check("reset_hi", dut.cpu.hi, 32'h0);
    check("reset_lo", dut.cpu.lo, 32'h0);

    #15 rst = 1'b1;
    wait_edge(1);
    check("edge1_ce", {31'h0, probe_bus.ce}, 32'h1);
    check("edge1_pc", probe_bus.pc, 32'h0);
    wait_edge(2);
    check("edge2_pc", probe_bus.pc, 32'h4);
    wait_edge(6);
    check("edge6_r1", dut.cpu.register.storage[1], 32'h0);
    check("edge6_hi", dut.cpu.hi, 32'h0);
    wait_edge(10);
    check("edge10_r4", dut.cpu.register.storage[4], 32'hFFFF_0000);
    wait_edge(16);
    check("edge16_hi", dut.cpu.hi, 32'h0505_0000);
    wait_edge(22);
    check("p1_r2", dut.cpu.register.storage[2], 32'hFFFF_0000);
    check("p1_r3", dut.cpu.register.storage[3], 32'h0505_0000);
    check("p1_r4", dut.cpu.register.storage[4], 32'h0);
    check("p1_hi", dut.cpu.hi, 32'h0505_0000);
    check("p1_lo", dut.cpu.lo, 32'h0);
    check("p1_pending", exp_q.size(), 32'd0);

    // Mid-run reset while ori $20 and mthi are still in flight.
    rst = 1'b0;
    #0.2;
    check("midrst_hi", dut.cpu.hi, 32'h0);
    check("midrst_pc", dut.cpu.pc, 32'h0);
    check("midrst_wb", {31'h0, dut.cpu.wb_wreg}, 32'h0);

    prog2[0]  = enc_i(6'h0D, 0, 5, 16'h1234);  prog2[1]  = enc_i(6'h0E, 5, 6, 16'h00FF);
    prog2[2]  = enc_i(6'h0C, 6, 7, 16'h0F0F);  prog2[3]  = enc_r(2, 3, 8, 0, 6'h24);
    prog2[4]  = enc_r(5, 2, 9, 0, 6'h25);      prog2[5]  = enc_r(9, 6, 10, 0, 6'h26);
    prog2[6]  = enc_r(5, 0, 11, 0, 6'h27);     prog2[7]  = enc_r(0, 5, 12, 4, 6'h00);
    prog2[8]  = enc_r(0, 2, 13, 8, 6'h02);     prog2[9]  = enc_r(0, 2, 14, 8, 6'h03);
    prog2[10] = 32'hFC0A_0001;                 prog2[11] = enc_i(6'h0D, 0, 16, 16'h0007);
    prog2[12] = enc_i(6'h0D, 0, 15, 16'h0001); prog2[13] = enc_r(5, 15, 16, 0, 6'h0A);
    prog2[14] = enc_r(16, 0, 22, 0, 6'h25);    prog2[15] = enc_r(9, 15, 17, 0, 6'h0B);
    prog2[16] = enc_r(5, 0, 0, 0, 6'h11);      prog2[17] = enc_r(6, 0, 0, 0, 6'h13);
    prog2[18] = enc_r(0, 0, 18, 0, 6'h10);     prog2[19] = enc_r(0, 0, 19, 0, 6'h12);
    prog2[20] = enc_r(18, 19, 20, 0, 6'h25);   prog2[21] = enc_r(5, 6, 21, 0, 6'h20);
    prog2[22] = enc_r(0, 5, 0, 4, 6'h00);      prog2[23] = enc_r(0, 5, 23, 0, 6'h25);
    prog2[24] = enc_r(2, 0, 0, 0, 6'h13);      prog2[25] = enc_r(0, 0, 24, 0, 6'h12);
    clear_rom();
    for (int i = 0; i < 26; i++) dut.inst_rom0.inst_mem[i] = prog2[i];

    gpr_exp[1]  = 32'h0000_0000; gpr_exp[2]  = 32'hFFFF_0000; gpr_exp[3]  = 32'h0505_0000;
    gpr_exp[4]  = 32'h0000_0000; gpr_exp[5]  = 32'h0000_1234; gpr_exp[6]  = 32'h0000_12CB;
    gpr_exp[7]  = 32'h0000_020B; gpr_exp[8]  = 32'h0505_0000; gpr_exp[9]  = 32'hFFFF_1234;
    gpr_exp[10] = 32'hFFFF_00FF; gpr_exp[11] = 32'hFFFF_EDCB; gpr_exp[12] = 32'h0001_2340;
    gpr_exp[13] = 32'h00FF_FF00; gpr_exp[14] = 32'hFFFF_FF00; gpr_exp[15] = 32'h0000_0001;
    gpr_exp[16] = 32'h0000_0007; gpr_exp[17] = 32'hFFFF_1234; gpr_exp[18] = 32'h0000_1234;
    gpr_exp[19] = 32'h0000_12CB; gpr_exp[20] = 32'h0000_12FF; gpr_exp[21] = 32'h0;
    gpr_exp[22] = 32'h0000_0007; gpr_exp[23] = 32'h0000_1234; gpr_exp[24] = 32'hFFFF_0000;

    push(6, 0, 5, gpr_exp[5]);    push(7, 0, 6, gpr_exp[6]);    push(8, 0, 7, gpr_exp[7]);
    push(9, 0, 8, gpr_exp[8]);    push(10, 0, 9, gpr_exp[9]);   push(11, 0, 10, gpr_exp[10]);
    push(12, 0, 11, gpr_exp[11]); push(13, 0, 12, gpr_exp[12]); push(14, 0, 13, gpr_exp[13]);
    push(15, 0, 14, gpr_exp[14]); push(17, 0, 16, 32'h7);       push(18, 0, 15, 32'h1);
    push(20, 0, 22, 32'h7);       push(21, 0, 17, gpr_exp[17]); push(22, 1, 0, 32'h0000_1234);
    push(23, 2, 0, 32'h0000_12CB); push(24, 0, 18, gpr_exp[18]); push(25, 0, 19, gpr_exp[19]);
    push(26, 0, 20, gpr_exp[20]); push(29, 0, 23, gpr_exp[23]); push(30, 2, 0, 32'hFFFF_0000);
    push(31, 0, 24, gpr_exp[24]);

    @(negedge clk);
    rst = 1'b1;
    wait_edge(36);
    for (int r = 1; r <= 24; r++) begin
      if (r != 21) check($sformatf("p2_r%0d", r), dut.cpu.register.storage[r], gpr_exp[r]);
    end
    check("p2_hi", dut.cpu.hi, 32'h0000_1234);
    check("p2_lo", dut.cpu.lo, 32'hFFFF_0000);
    check("p2_pending", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
